// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC constants and input-port FSM encoding
package noc_pkg;

    localparam int FLIT_WIDTH_DEF   = 32;
    localparam int FLITS_PER_PACKET = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } port_state_e;

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - first-word fall-through flit storage with occupancy counter
module flit_fifo
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    // caller only raises push/pop when they are legal (not full unless popping, not empty)
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [FLIT_WIDTH-1:0] i_din,
    output logic [FLIT_WIDTH-1:0] o_dout,
    output logic [AW:0]           o_count,
    output logic [AW:0]           o_count_next,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic [AW:0]           w_count_next;

    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_full       = (r_count == CNT_FULL);
    assign o_empty      = (r_count == '0);
    // head flit falls through; forced to zero when empty so stale storage never shows
    assign o_dout       = o_empty ? '0 : r_mem[r_rptr];

    // occupancy after this cycle's push/pop; unchanged when both happen
    always_comb begin
        w_count_next = r_count;
        if (i_push && !i_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (!i_push && i_pop) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    // storage write; no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // pointers wrap naturally modulo DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_ONE;
            if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/input_port_buffer.sv
// rtl/input_port_buffer.sv - router input port: flit buffer, packet FSM, ON/OFF flow control
module input_port_buffer
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
    parameter int DEPTH      = 8,
    parameter int OFF_THRESH = DEPTH - 2,
    parameter int ON_THRESH  = DEPTH - 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] flit_in,
    input  logic                  flit_in_valid,
    output logic                  ON_OFF_signal,
    output logic                  req,
    input  logic                  grant,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  flit_out_valid,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] OFF_LVL   = (AW+1)'(OFF_THRESH);
    localparam logic [AW:0] ON_LVL    = (AW+1)'(ON_THRESH);
    localparam logic [AW:0] PKT_LVL   = (AW+1)'(FLITS_PER_PACKET);
    localparam logic [1:0]  LAST_FLIT = 2'(FLITS_PER_PACKET - 1);

    logic [AW:0]   w_count;
    logic [AW:0]   w_count_next;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;

    port_state_e   r_state;
    port_state_e   w_state_next;
    logic [1:0]    r_fcnt;
    logic [1:0]    w_fcnt_next;
    logic          w_req;

    // a pop needs a grant and data; a write is accepted unless full without a pop
    assign w_pop          = grant & ~w_empty;
    assign w_push         = flit_in_valid & (~w_full | w_pop);
    assign flit_out_valid = w_pop;
    assign req            = w_req;

    flit_fifo #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_din        (flit_in),
        .o_dout       (flit_out),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // packet FSM: request once a whole packet is buffered, hold request until its tail leaves
    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        w_req        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req = (w_count >= PKT_LVL);
                if (w_pop) begin
                    w_state_next = ST_SEND;
                    w_fcnt_next  = 2'd1;
                end
            end
            ST_SEND: begin
                w_req = 1'b1;
                if (w_pop) begin
                    if (r_fcnt == LAST_FLIT) begin
                        w_state_next = ST_IDLE;
                        w_fcnt_next  = 2'd0;
                    end else begin
                        w_fcnt_next = r_fcnt + 2'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_fcnt_next  = 2'd0;
            end
        endcase
    end

    // FSM state and flit counter registers; a stalled grant simply holds them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_fcnt  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    // ON/OFF with hysteresis, judged on the occupancy this cycle leaves behind
    always_ff @(posedge clk) begin
        if (rst) begin
            ON_OFF_signal <= 1'b0;
        end else if (w_count_next >= OFF_LVL) begin
            ON_OFF_signal <= 1'b1;
        end else if (w_count_next <= ON_LVL) begin
            ON_OFF_signal <= 1'b0;
        end
    end

    // sticky protocol error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (flit_in_valid && w_full && !w_pop) overflow_err  <= 1'b1;
            if (grant && w_empty)                  underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// tb/tb_input_port_buffer.sv - scoreboard bench for input_port_buffer
module tb_input_port_buffer;

    localparam int FW    = 32;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic [FW-1:0] flit_in;
    logic          flit_in_valid;
    logic          ON_OFF_signal;
    logic          req;
    logic          grant;
    logic [FW-1:0] flit_out;
    logic          flit_out_valid;
    logic          overflow_err;
    logic          underflow_err;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [FW-1:0] sb_q[$];
    logic [FW-1:0] dval = 32'hA000_0000;
    logic [FW-1:0] first_val;

    input_port_buffer #(
        .FLIT_WIDTH (FW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_in        (flit_in),
        .flit_in_valid  (flit_in_valid),
        .ON_OFF_signal  (ON_OFF_signal),
        .req            (req),
        .grant          (grant),
        .flit_out       (flit_out),
        .flit_out_valid (flit_out_valid),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive inputs, score output at negedge, return 1ns after the rising edge
    task automatic cyc(input logic v, input logic [FW-1:0] d, input logic g);
        logic          pop_m;
        logic          push_m;
        logic [FW-1:0] e;
        flit_in_valid = v;
        flit_in       = d;
        grant         = g;
        @(negedge clk);
        pop_m  = g && (sb_q.size() > 0);
        push_m = v && ((sb_q.size() < DEPTH) || pop_m);
        check("flit_out_valid", 64'(flit_out_valid), 64'(pop_m));
        if (pop_m) begin
            e = sb_q.pop_front();
            check("flit_out", 64'(flit_out), 64'(e));
        end
        if (push_m) sb_q.push_back(d);
        @(posedge clk);
        #1;
        flit_in_valid = 1'b0;
        grant         = 1'b0;
    endtask

    task automatic wr(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, dval, 1'b0);
            dval = dval + 32'd1;
        end
    endtask

    task automatic gr(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
    endtask

    // reset with a write and grant pending; both must be ignored
    task automatic do_reset();
        rst           = 1'b1;
        flit_in_valid = 1'b1;
        flit_in       = 32'hDEAD_BEEF;
        grant         = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        flit_in_valid = 1'b0;
        grant         = 1'b0;
        sb_q.delete();
        check("rst_req",      64'(req),           64'd0);
        check("rst_onoff",    64'(ON_OFF_signal), 64'd0);
        check("rst_ovf",      64'(overflow_err),  64'd0);
        check("rst_unf",      64'(underflow_err), 64'd0);
        check("rst_flit_out", 64'(flit_out),      64'd0);
        grant = 1'b1;
        #1;
        check("rst_fov", 64'(flit_out_valid), 64'd0);
        grant = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        flit_in       = '0;
        flit_in_valid = 1'b0;
        grant         = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // three flits do not make a packet; the fourth raises req
        first_val = dval;
        wr(1);
        check("fwft_head", 64'(flit_out), 64'(first_val));
        check("req_1flit", 64'(req), 64'd0);
        wr(2);
        check("req_3flits", 64'(req), 64'd0);
        wr(1);
        check("req_4flits", 64'(req), 64'd1);
        for (int i = 0; i < 4; i++) begin
            gr(1);
            check(i < 3 ? "req_in_pkt" : "req_after_tail", 64'(req), (i < 3) ? 64'd1 : 64'd0);
        end

        // ON/OFF hysteresis, then an arbiter stall mid-packet
        wr(5);
        check("onoff_5", 64'(ON_OFF_signal), 64'd0);
        wr(1);
        check("onoff_6", 64'(ON_OFF_signal), 64'd1);
        gr(1);
        check("onoff_hold_5", 64'(ON_OFF_signal), 64'd1);
        gr(1);
        check("onoff_rel_4", 64'(ON_OFF_signal), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b0);
            check("req_stall", 64'(req), 64'd1);
        end
        gr(1);
        check("req_fcnt3", 64'(req), 64'd1);
        gr(1);
        check("req_pkt_done", 64'(req), 64'd0);
        wr(2);
        check("req_refill", 64'(req), 64'd1);
        gr(4);
        check("req_drained", 64'(req), 64'd0);

        // overflow drop, then simultaneous push/pop while full
        wr(8);
        check("onoff_full", 64'(ON_OFF_signal), 64'd1);
        cyc(1'b1, 32'hBAD0_0009, 1'b0);
        check("ovf_set", 64'(overflow_err), 64'd1);
        cyc(1'b1, dval, 1'b1);
        dval = dval + 32'd1;
        check("ovf_sticky", 64'(overflow_err), 64'd1);
        check("onoff_full_pp", 64'(ON_OFF_signal), 64'd1);
        gr(8);
        check("onoff_empty", 64'(ON_OFF_signal), 64'd0);
        check("unf_clean", 64'(underflow_err), 64'd0);

        // reset mid-packet with backlog, then grant on empty
        do_reset();
        wr(8);
        gr(2);
        do_reset();
        cyc(1'b0, '0, 1'b1);
        check("unf_set", 64'(underflow_err), 64'd1);
        check("req_empty", 64'(req), 64'd0);
        cyc(1'b0, '0, 1'b0);
        check("unf_sticky", 64'(underflow_err), 64'd1);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
